// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between two requesters,
// with registered read data and a one-cycle rvalid pulse per granted read.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);
  localparam logic [1:0] IDLE = 2'd0, SERVE0 = 2'd1, SERVE1 = 2'd2;
  logic [1:0] state, state_nxt, arb_nxt;
  logic       last_gnt;
  always_comb begin
    // a tie goes to whichever requester was not served most recently
    arb_nxt        = (req0 && req1) ? (last_gnt ? SERVE0 : SERVE1) :
                     req0 ? SERVE0 : req1 ? SERVE1 : IDLE;
    gnt0           = rst && state == SERVE0 && req0;
    gnt1           = rst && state == SERVE1 && req1;
    state_nxt      = gnt0 ? (req1 ? SERVE1 : SERVE0) :
                     gnt1 ? (req0 ? SERVE0 : SERVE1) : arb_nxt;
    mem_write      = gnt0 ? we0 : gnt1 ? we1 : 1'b0;
    mem_address    = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    mem_write_data = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= gnt0 ? 1'b0 : gnt1 ? 1'b1 : last_gnt;
      rvalid0  <= gnt0 && !we0;
      rvalid1  <= gnt1 && !we1;
      if (gnt0 && !we0) rdata0 <= mem_read_data;
      if (gnt1 && !we1) rdata1 <= mem_read_data;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios against a behavioural memory on the shared port.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_write;
  logic [31:0] rdata0, rdata1, mem_write_data, mem_read_data;
  logic [7:0]  mem_address;
  logic        pre_en = 1'b0;
  logic [7:0]  pre_a = '0;
  logic [31:0] pre_d = '0;
  logic [31:0] mem [0:255];
  int passed = 0, total = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
    else if (pre_en) mem[pre_a] <= pre_d;
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    @(posedge clk); #1 pre_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 8'h33; wdata0 = 32'h12345678;
    preload(8'h00, 32'hA5A5A5A5);
    preload(8'hFF, 32'h00001234);
    preload(8'h05, 32'h00005555);
    @(negedge clk);
    total++; if (gnt0 !== 1'b0) $display("FAIL rst_gnt0: got %b want 0", gnt0); else passed++;
    total++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write: got %b want 0", mem_write); else passed++;
    total++; if (mem_address !== 8'h00) $display("FAIL rst_mem_address: got %h want 00", mem_address); else passed++;
    total++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {rvalid0, rvalid1}); else passed++;
    total++; if ({rdata0, rdata1} !== 64'h0) $display("FAIL rst_rdata: got %h want 0", {rdata0, rdata1}); else passed++;
    @(posedge clk); #1 req0 = 1'b0; we0 = 1'b0; rst = 1'b1;
  endtask

  task automatic test_write_read();
    @(posedge clk); #1 req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (gnt0 !== 1'b0) $display("FAIL wr_latency_gnt0: got %b want 0", gnt0); else passed++;
    @(negedge clk);
    total++; if ({gnt0, gnt1, mem_write} !== 3'b101) $display("FAIL wr_gnt_write: got %b want 101", {gnt0, gnt1, mem_write}); else passed++;
    total++; if (mem_address !== 8'h10) $display("FAIL wr_address: got %h want 10", mem_address); else passed++;
    total++; if (mem_write_data !== 32'hDEADBEEF) $display("FAIL wr_data: got %h want deadbeef", mem_write_data); else passed++;
    @(posedge clk); #1 we0 = 1'b0;
    @(negedge clk);
    total++; if ({gnt0, mem_write} !== 2'b10) $display("FAIL rd_gnt0: got %b want 10", {gnt0, mem_write}); else passed++;
    total++; if (mem[8'h10] !== 32'hDEADBEEF) $display("FAIL wr_commit: got %h want deadbeef", mem[8'h10]); else passed++;
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    total++; if (rvalid0 !== 1'b1) $display("FAIL rd_rvalid0: got %b want 1", rvalid0); else passed++;
    total++; if (rdata0 !== 32'hDEADBEEF) $display("FAIL rd_rdata0: got %h want deadbeef", rdata0); else passed++;
    total++; if (gnt0 !== 1'b0) $display("FAIL rd_withdrawn_gnt0: got %b want 0", gnt0); else passed++;
    @(negedge clk);
    total++; if (rvalid0 !== 1'b0) $display("FAIL rd_rvalid0_pulse: got %b want 0", rvalid0); else passed++;
    total++; if (rdata0 !== 32'hDEADBEEF) $display("FAIL rd_rdata0_hold: got %h want deadbeef", rdata0); else passed++;
  endtask

  task automatic test_tie();
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    @(negedge clk);
    total++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL tie_idle: got %b want 00", {gnt0, gnt1}); else passed++;
    @(negedge clk);
    total++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL tie_first: got %b want 10", {gnt0, gnt1}); else passed++;
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    total++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL tie_second: got %b want 01", {gnt0, gnt1}); else passed++;
    total++; if (rvalid0 !== 1'b1) $display("FAIL tie_rvalid0: got %b want 1", rvalid0); else passed++;
    @(posedge clk); #1 req1 = 1'b0;
    @(negedge clk);
    total++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL tie_after: got %b want 00", {gnt0, gnt1}); else passed++;
    total++; if (rvalid1 !== 1'b1) $display("FAIL tie_rvalid1: got %b want 1", rvalid1); else passed++;
    @(negedge clk);
    total++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL tie_idle_end: got %b want 00", {gnt0, gnt1}); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    @(posedge clk); #1 req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      want = (k % 2 == 0) ? 2'b10 : 2'b01;
      total++; if ({gnt0, gnt1} !== want) $display("FAIL alt_cycle%0d: got %b want %b", k, {gnt0, gnt1}, want); else passed++;
    end
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL alt_idle: got %b want 00", {gnt0, gnt1}); else passed++;
  endtask

  task automatic test_reset_mid_serve();
    @(posedge clk); #1 req1 = 1'b1; we1 = 1'b1; addr1 = 8'hFF; wdata1 = 32'h1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if ({gnt1, mem_write} !== 2'b00) $display("FAIL rstmid_forced: got %b want 00", {gnt1, mem_write}); else passed++;
    @(posedge clk); #1 rst = 1'b1; we1 = 1'b0;
    @(negedge clk);
    total++; if (gnt1 !== 1'b0) $display("FAIL rstmid_idle_gnt1: got %b want 0", gnt1); else passed++;
    total++; if (mem[8'hFF] !== 32'h1234) $display("FAIL rstmid_mem: got %h want 00001234", mem[8'hFF]); else passed++;
    @(negedge clk);
    total++; if ({gnt1, mem_write} !== 2'b10) $display("FAIL rstmid_regrant: got %b want 10", {gnt1, mem_write}); else passed++;
    @(posedge clk); #1 req1 = 1'b0;
    @(negedge clk);
    total++; if ({rvalid1, rdata1} !== {1'b1, 32'h1234}) $display("FAIL rstmid_read: got %b/%h want 1/00001234", rvalid1, rdata1); else passed++;
  endtask

  task automatic test_withdraw();
    @(posedge clk); #1 req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
    @(posedge clk); #1 req1 = 1'b0;
    @(negedge clk);
    total++; if (gnt1 !== 1'b0) $display("FAIL wd_gnt1: got %b want 0", gnt1); else passed++;
    @(negedge clk);
    total++; if (rvalid1 !== 1'b0) $display("FAIL wd_rvalid1: got %b want 0", rvalid1); else passed++;
    total++; if (rdata1 !== 32'h1234) $display("FAIL wd_rdata1: got %h want 00001234", rdata1); else passed++;
  endtask

  task automatic test_read_then_write();
    @(posedge clk); #1 req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
    @(negedge clk);
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) $display("FAIL rw_gnt0: got %b want 1", gnt0); else passed++;
    @(posedge clk); #1 we0 = 1'b1; wdata0 = 32'h11111111;
    @(negedge clk);
    total++; if ({rvalid0, mem_write} !== 2'b11) $display("FAIL rw_rvalid_write: got %b want 11", {rvalid0, mem_write}); else passed++;
    total++; if (rdata0 !== 32'hA5A5A5A5) $display("FAIL rw_rdata0: got %h want a5a5a5a5", rdata0); else passed++;
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    total++; if (rvalid0 !== 1'b0) $display("FAIL rw_no_rvalid: got %b want 0", rvalid0); else passed++;
    total++; if (rdata0 !== 32'hA5A5A5A5) $display("FAIL rw_rdata0_hold: got %h want a5a5a5a5", rdata0); else passed++;
    total++; if (mem[8'h00] !== 32'h11111111) $display("FAIL rw_commit: got %h want 11111111", mem[8'h00]); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_back_to_back();
    test_reset_mid_serve();
    test_withdraw();
    test_read_then_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the width of the memory word address.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the memory word width.
REQ-003 clk  input  1  the single clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req0 / req1  input  1  access request from requester 0 (CPU data) / requester 1 (loader).
REQ-006 we0 / we1  input  1  request type: 1 = write, 0 = read.
REQ-007 addr0 / addr1  input  ADDR_W  word address.
REQ-008 wdata0 / wdata1  input  DATA_W  write data.
REQ-009 gnt0 / gnt1  output  1  high in the cycle the requester's access is performed.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse: read data valid.
REQ-011 rdata0 / rdata1  output  DATA_W  registered read data.
REQ-012 mem_write  output  1  drives the shared memory port write enable.
REQ-013 mem_address  output  ADDR_W  drives the shared memory port address.
REQ-014 mem_write_data  output  DATA_W  drives the shared memory port write data.
REQ-015 mem_read_data  input  DATA_W  asynchronous read data from the memory port.

Function
REQ-016 FSM states SHALL be IDLE, SERVE0 and SERVE1; a one-bit pointer last_gnt SHALL record the most recently served requester.
REQ-017 IDLE: if exactly one req is high, next state is SERVE for that requester; if both are high, next state is SERVE for the requester not equal to last_gnt; if neither is high, stay in IDLE.
REQ-018 SERVEx with reqx high: gntx = 1; mem_address = addrx; mem_write_data = wdatax; mem_write = wex; last_gnt <= x at the posedge.
REQ-019 The next state after SERVEx SHALL be SERVE of the other requester if it is requesting, else SERVEx if reqx is still high, else IDLE; there is no idle bubble between back-to-back grants.
REQ-020 A requester SHALL hold req, we, addr and wdata stable until it samples its gnt high; it drops req, or presents a new request, in the following cycle.
REQ-021 If reqx is low while in SERVEx (request withdrawn), the access SHALL be aborted: gntx = 0, mem_write = 0, and the next state is computed as in IDLE.
REQ-022 Latency: gnt SHALL assert no earlier than 1 cycle after req rises from IDLE; a write commits at the posedge ending the gnt cycle.
REQ-023 For a granted read, rdatax <= mem_read_data at the posedge ending the gnt cycle, and rvalidx = 1 for exactly the next cycle.
REQ-024 rdatax SHALL hold its value until the next granted read of that requester; no rvalid pulse is generated for writes.
REQ-025 Outside SERVE states, mem_write SHALL be 0 and mem_address/mem_write_data SHALL be 0.
REQ-026 At most one of gnt0/gnt1 SHALL be high in any cycle, and mem_write SHALL never be high without a gnt.
REQ-027 With both requesters continuously requesting, grants SHALL alternate every cycle, so neither requester waits more than 2 cycles.

Reset
REQ-028 While rst = 0 at a posedge: state <= IDLE, last_gnt <= 1 (requester 0 wins the first tie), rdata0/rdata1 <= 0, rvalid0/rvalid1 <= 0.
REQ-029 While rst = 0, gnt0, gnt1 and mem_write SHALL be forced to 0 combinationally, so no memory write occurs during reset, including reset asserted mid-SERVE.
REQ-030 The first grant after rst returns high SHALL occur no earlier than 1 cycle after the release.

Verification
REQ-031 Scenario: after reset, req0 write addr 0x10 data 0xDEADBEEF -> gnt0 one cycle later with mem_write=1 and mem_address=0x10; a subsequent req0 read of 0x10 -> rvalid0 pulse with rdata0=0xDEADBEEF.
REQ-032 Scenario: req0 and req1 both rise in the same cycle from IDLE after reset -> gnt0 first, gnt1 the next cycle, then idle.
REQ-033 Scenario: req0 and req1 held high for 6 cycles -> gnt sequence 0,1,0,1,0,1 with no cycle having both grants.
REQ-034 Scenario: req1 write addr 0xFF data 0x1 with rst driven low in the gnt cycle -> mem_write=0 and memory[0xFF] unchanged; state IDLE after the reset.
REQ-035 Scenario: req1 read withdrawn in its SERVE1 cycle -> no gnt1, no rvalid1, rdata1 unchanged.
REQ-036 Scenario: req0 read of 0x00 with memory[0x00]=0xA5A5A5A5, followed by req0 write of 0x00 -> rdata0 stays 0xA5A5A5A5 after the write, with no rvalid0 for the write.
